instr_enc: RTL and testbench

- Instruction encoder: inverse of the immediate decode path. Takes RV32I instruction fields plus a 32-bit immediate value and packs them into a 32-bit instruction word.
- Range-checks the immediate against the format selected by opcode.
- Two-stage valid/ready pipeline. Sits between the debug/test program loader and instruction memory write port.
- Illegal requests emit a NOP and are flagged and counted.

---
 rtl/instr_enc.sv | 158 +++++++++++++++
 tb/tb_instr_enc.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_enc.sv
// RV32I instruction encoder: packs decoded fields plus an immediate into a 32-bit word,
// range-checks the immediate for the opcode's format, and substitutes a NOP on violation.
module instr_enc #(
    parameter int unsigned ERR_CNT_W = 16,
    parameter logic [31:0] NOP_WORD  = 32'h0000_0013
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [6:0]           in_opcode,
    input  logic [4:0]           in_rd,
    input  logic [4:0]           in_rs1,
    input  logic [4:0]           in_rs2,
    input  logic [2:0]           in_funct3,
    input  logic [6:0]           in_funct7,
    input  logic [31:0]          in_imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_instr,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD
    } fmt_t;

    // True when bits [31:nbits-1] are all equal, i.e. v fits an nbits-wide signed field.
    function automatic logic fits_signed(input logic signed [31:0] v, input int unsigned nbits);
        logic signed [31:0] t;
        t = v >>> (nbits - 1);
        return (&t) || (~|t);
    endfunction

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    logic               r_vld_p1;
    logic [6:0]         r_opcode_p1;
    logic [4:0]         r_rd_p1;
    logic [4:0]         r_rs1_p1;
    logic [4:0]         r_rs2_p1;
    logic [2:0]         r_funct3_p1;
    logic [6:0]         r_funct7_p1;
    logic signed [31:0] r_imm_p1;

    logic                 r_vld_p2;
    logic [31:0]          r_instr_p2;
    logic                 r_err_p2;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    logic        w_s2_load;
    fmt_t        w_fmt;
    logic [31:0] w_raw;
    logic        w_bad;
    logic [31:0] w_instr;

    assign w_s2_load = !r_vld_p2 || out_ready;
    assign in_ready  = !r_vld_p1 || w_s2_load;

    assign out_valid = r_vld_p2;
    assign out_instr = r_instr_p2;
    assign out_err   = r_err_p2;
    assign err_cnt   = r_err_cnt;

    // Stage 1 boundary: capture raw request fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p1 <= 1'b0;
        end else if (in_ready) begin
            r_vld_p1 <= in_valid;
        end
        if (in_valid && in_ready) begin
            r_opcode_p1 <= in_opcode;
            r_rd_p1     <= in_rd;
            r_rs1_p1    <= in_rs1;
            r_rs2_p1    <= in_rs2;
            r_funct3_p1 <= in_funct3;
            r_funct7_p1 <= in_funct7;
            r_imm_p1    <= in_imm;
        end
    end

    always_comb begin
        w_fmt = FMT_BAD;
        case (r_opcode_p1)
            7'b0010011: w_fmt = (r_funct3_p1 == 3'd1 || r_funct3_p1 == 3'd5) ? FMT_SH : FMT_I;
            7'b0000011, 7'b1100111, 7'b1110011: w_fmt = FMT_I;
            7'b0100011: w_fmt = FMT_S;
            7'b1100011: w_fmt = FMT_B;
            7'b0110111, 7'b0010111: w_fmt = FMT_U;
            7'b1101111: w_fmt = FMT_J;
            7'b0110011: w_fmt = FMT_R;
            default:    w_fmt = FMT_BAD;
        endcase
    end

    always_comb begin
        w_raw = '0;
        w_bad = 1'b0;
        case (w_fmt)
            FMT_R: w_raw = {r_funct7_p1, r_rs2_p1, r_rs1_p1, r_funct3_p1, r_rd_p1, r_opcode_p1};
            FMT_I: begin
                w_raw = {r_imm_p1[11:0], r_rs1_p1, r_funct3_p1, r_rd_p1, r_opcode_p1};
                w_bad = !fits_signed(r_imm_p1, 12);
            end
            FMT_SH: begin
                w_raw = {r_funct7_p1, r_imm_p1[4:0], r_rs1_p1, r_funct3_p1, r_rd_p1, r_opcode_p1};
                w_bad = |r_imm_p1[31:5];
            end
            FMT_S: begin
                w_raw = {r_imm_p1[11:5], r_rs2_p1, r_rs1_p1, r_funct3_p1, r_imm_p1[4:0], r_opcode_p1};
                w_bad = !fits_signed(r_imm_p1, 12);
            end
            FMT_B: begin
                w_raw = {r_imm_p1[12], r_imm_p1[10:5], r_rs2_p1, r_rs1_p1, r_funct3_p1,
                         r_imm_p1[4:1], r_imm_p1[11], r_opcode_p1};
                w_bad = !fits_signed(r_imm_p1, 13) || r_imm_p1[0];
            end
            FMT_U: begin
                w_raw = {r_imm_p1[31:12], r_rd_p1, r_opcode_p1};
                w_bad = |r_imm_p1[11:0];
            end
            FMT_J: begin
                w_raw = {r_imm_p1[20], r_imm_p1[10:1], r_imm_p1[11], r_imm_p1[19:12],
                         r_rd_p1, r_opcode_p1};
                w_bad = !fits_signed(r_imm_p1, 21) || r_imm_p1[0];
            end
            default: w_bad = 1'b1;
        endcase
    end

    assign w_instr = w_bad ? NOP_WORD : w_raw;

    // Stage 2 boundary: packed word, error flag and handoff-side error count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p2   <= 1'b0;
            r_instr_p2 <= '0;
            r_err_p2   <= 1'b0;
            r_err_cnt  <= '0;
        end else begin
            if (r_vld_p2 && out_ready && r_err_p2) begin
                r_err_cnt <= sat_inc(r_err_cnt);
            end
            if (w_s2_load) begin
                r_vld_p2 <= r_vld_p1;
                if (r_vld_p1) begin
                    r_instr_p2 <= w_instr;
                    r_err_p2   <= w_bad;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_enc.sv
// Bench for instr_enc: directed vectors, backpressure, mid-stream reset and saturation,
// plus randomized traffic scored against a format-rule reference model.
module tb_instr_enc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;
    logic [15:0] err_cnt;

    logic        sat_valid;
    logic        sat_in_ready, sat_out_valid, sat_out_err;
    logic [31:0] sat_out_instr;
    logic [2:0]  sat_cnt;

    always #5 clk = ~clk;

    instr_enc dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_err(out_err), .err_cnt(err_cnt)
    );

    // Narrow counter instance so saturation is reachable in a few cycles.
    instr_enc #(.ERR_CNT_W(3)) u_sat (
        .clk(clk), .rst(rst),
        .in_valid(sat_valid), .in_ready(sat_in_ready),
        .in_opcode(7'h7F), .in_rd(5'd0), .in_rs1(5'd0), .in_rs2(5'd0),
        .in_funct3(3'd0), .in_funct7(7'd0), .in_imm(32'd0),
        .out_valid(sat_out_valid), .out_ready(1'b1),
        .out_instr(sat_out_instr), .out_err(sat_out_err), .err_cnt(sat_cnt)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    // Reference: returns {err, word}, derived from the RV32I field layout and value ranges.
    function automatic logic [32:0] model(input logic [6:0] op, input logic [4:0] d,
                                          input logic [4:0] s1, input logic [4:0] s2,
                                          input logic [2:0] f, input logic [6:0] f7,
                                          input logic [31:0] imm);
        int signed  s;
        logic       ok;
        logic [31:0] w, base;
        s    = $signed(imm);
        base = 32'(op) | (32'(d) << 7) | (32'(f) << 12) | (32'(s1) << 15);
        ok   = 1'b0;
        w    = '0;
        case (op)
            7'h13, 7'h03, 7'h67, 7'h73: begin
                if (op == 7'h13 && (f == 3'd1 || f == 3'd5)) begin
                    ok = imm < 32;
                    w  = base | (imm << 20) | (32'(f7) << 25);
                end else begin
                    ok = s >= -2048 && s <= 2047;
                    w  = base | ((imm & 32'hFFF) << 20);
                end
            end
            7'h23: begin
                ok = s >= -2048 && s <= 2047;
                w  = 32'(op) | ((imm & 32'h1F) << 7) | (32'(f) << 12) | (32'(s1) << 15)
                   | (32'(s2) << 20) | (((imm >> 5) & 32'h7F) << 25);
            end
            7'h63: begin
                ok = s >= -4096 && s <= 4095 && imm[0] == 1'b0;
                w  = 32'(op) | (((imm >> 11) & 1) << 7) | (((imm >> 1) & 32'hF) << 8)
                   | (32'(f) << 12) | (32'(s1) << 15) | (32'(s2) << 20)
                   | (((imm >> 5) & 32'h3F) << 25) | (((imm >> 12) & 1) << 31);
            end
            7'h37, 7'h17: begin
                ok = (imm % 4096) == 0;
                w  = 32'(op) | (32'(d) << 7) | (imm & 32'hFFFF_F000);
            end
            7'h6F: begin
                ok = s >= -1048576 && s <= 1048575 && imm[0] == 1'b0;
                w  = 32'(op) | (32'(d) << 7) | (((imm >> 12) & 32'hFF) << 12)
                   | (((imm >> 11) & 1) << 20) | (((imm >> 1) & 32'h3FF) << 21)
                   | (((imm >> 20) & 1) << 31);
            end
            7'h33: begin
                ok = 1'b1;
                w  = base | (32'(s2) << 20) | (32'(f7) << 25);
            end
            default: ok = 1'b0;
        endcase
        return ok ? {1'b0, w} : {1'b1, 32'h0000_0013};
    endfunction

    logic [32:0] sb[$];
    logic        dir_mode = 1'b0;
    logic [31:0] dir_instr;
    logic        dir_err;
    logic        acc_flag = 1'b0;
    int          m_err = 0;
    logic        hold_v = 1'b0;
    logic [31:0] hold_i;
    logic        hold_e;

    // Monitor: hold-stability, scoreboard pops on handoff, pushes on accept.
    initial forever begin
        logic [32:0] e;
        @(negedge clk);
        acc_flag = !rst && in_valid && in_ready;
        if (rst) begin
            sb.delete();
            m_err  = 0;
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_instr", out_instr, hold_i);
                chk("hold_err", 32'(out_err), 32'(hold_e));
            end
            if (out_valid && out_ready) begin
                chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("instr", out_instr, e[31:0]);
                    chk("err", 32'(out_err), 32'(e[32]));
                    if (e[32]) m_err++;
                end
            end
            if (in_valid && in_ready)
                sb.push_back(dir_mode ? {dir_err, dir_instr}
                                      : model(in_opcode, in_rd, in_rs1, in_rs2,
                                              in_funct3, in_funct7, in_imm));
            hold_v = out_valid && !out_ready;
            hold_i = out_instr;
            hold_e = out_err;
        end
    end

    task automatic drive(input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1,
                         input logic [4:0] s2, input logic [2:0] f, input logic [6:0] f7,
                         input logic [31:0] imm);
        in_opcode = op; in_rd = d; in_rs1 = s1; in_rs2 = s2;
        in_funct3 = f; in_funct7 = f7; in_imm = imm;
        in_valid  = 1'b1;
    endtask

    task automatic send(input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [2:0] f, input logic [6:0] f7,
                        input logic [31:0] imm);
        int n;
        @(posedge clk); #1;
        drive(op, d, s1, s2, f, f7, imm);
        n = 0;
        do begin @(negedge clk); n++; end while (!in_ready && n < 50);
        chk("send_accept", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic dsend(input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1,
                         input logic [4:0] s2, input logic [2:0] f, input logic [31:0] imm,
                         input logic [31:0] exp_i, input logic exp_e);
        dir_mode  = 1'b1;
        dir_instr = exp_i;
        dir_err   = exp_e;
        send(op, d, s1, s2, f, 7'd0, imm);
        dir_mode  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin @(negedge clk); n++; end
        chk("drain", 32'(sb.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] ops [13] = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37,
                                 7'h17, 7'h6F, 7'h33, 7'h7F, 7'h00, 7'h0B};
        logic [31:0] imm;
        int n_acc;
        in_valid = 1'b0; out_ready = 1'b1; sat_valid = 1'b0;
        drive(7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        dsend(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0);
        @(negedge clk);
        chk("latency_edge1", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("latency_edge2", 32'(out_valid), 32'd1);

        dsend(7'h23, 5'd0, 5'd3, 5'd2, 3'd2, 32'd8,          32'h0021_A423, 1'b0);
        dsend(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5000,  32'h1234_52B7, 1'b0);
        dsend(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFC,  32'hFE00_0EE3, 1'b0);
        dsend(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'h0000_0800,  32'h0010_00EF, 1'b0);
        dsend(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048,       32'h0000_0013, 1'b1);
        dsend(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'd3,          32'h0000_0013, 1'b1);
        dsend(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 32'h0000_1001,  32'h0000_0013, 1'b1);
        dsend(7'h7F, 5'd1, 5'd1, 5'd1, 3'd0, 32'd0,          32'h0000_0013, 1'b1);
        drain();
        chk("err_cnt_four", 32'(err_cnt), 32'd4);

        // Backpressure: four offered, two fit.
        @(posedge clk); #1 out_ready = 1'b0;
        n_acc = 0;
        for (int k = 1; k <= 4; k++) begin
            drive(7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'(k));
            @(negedge clk);
            if (in_ready) n_acc++;
            @(posedge clk); #1;
        end
        chk("bp_accepted", 32'(n_acc), 32'd2);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_head", out_instr, 32'h0010_0113);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
        send(7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
        send(7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4);
        drain();

        // Randomized traffic with random backpressure.
        @(posedge clk); #1;
        for (int c = 0; c < 800; c++) begin
            if (acc_flag || !in_valid) begin
                if ($urandom_range(0, 3) != 0) begin
                    case ($urandom_range(0, 4))
                        0: imm = $urandom;
                        1: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
                        2: imm = $urandom & 32'hFFFF_F000;
                        3: imm = 32'($urandom_range(0, 63));
                        default: imm = (32'($urandom_range(0, 2097151)) - 32'h0010_0000)
                                       & ~32'($urandom_range(0, 1));
                    endcase
                    drive(ops[$urandom_range(0, 12)], 5'($urandom), 5'($urandom),
                          5'($urandom), 3'($urandom), 7'($urandom), imm);
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();
        chk("err_cnt_random", 32'(err_cnt), 32'(m_err));

        // Reset with two requests in flight.
        out_ready = 1'b0;
        drive(7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        @(posedge clk); #1;
        drive(7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd6);
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_err_cnt", 32'(err_cnt), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("midrst_no_stale", 32'(out_valid), 32'd0);
        end
        send(7'h33, 5'd7, 5'd8, 5'd9, 3'd0, 7'h20, 32'hDEAD_BEEF);
        drain();

        // Saturation on the narrow counter.
        @(posedge clk); #1 sat_valid = 1'b1;
        repeat (12) @(posedge clk);
        #1 sat_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("sat_reached", 32'(sat_cnt), 32'd7);
        @(posedge clk); #1 sat_valid = 1'b1;
        repeat (4) @(posedge clk);
        #1 sat_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("sat_held", 32'(sat_cnt), 32'd7);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
